// File: rtl/spi_temp_sequencer_if.sv
// FIFO-side bus between the temperature sequencer and the SPI core.
// master = sequencer, slave = SPI core.
interface spi_temp_sequencer_if;
    logic       wfwe;
    logic [7:0] wfdin;
    logic       wfull;
    logic       rfre;
    logic [7:0] rfdout;
    logic       rempty;
    logic       ncs;

    modport master (
        output wfwe, wfdin, rfre, ncs,
        input  wfull, rfdout, rempty
    );

    modport slave (
        input  wfwe, wfdin, rfre, ncs,
        output wfull, rfdout, rempty
    );
endinterface

// File: rtl/spi_temp_sequencer.sv
// Periodic SPI temperature poller and host/poller FIFO arbiter.
// Optional: SPI_TEMP_SEQ_ALIGN_EN sign-extends the 13-bit reading (>>>3).
module spi_temp_sequencer #(
    parameter int POLL_INTERVAL = 1000000,
    parameter int CS_SETUP      = 4,
    parameter int CS_HOLD       = 4,
    parameter int TIMEOUT       = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        host_wfwe,
    input  logic [7:0]                  host_wfdin,
    input  logic                        host_rfre,
    input  logic                        host_ncs,
    input  logic                        host_clr_err,
    spi_temp_sequencer_if.master        spi,
    output logic                        busy,
    output logic                        collision,
    output logic                        timeout_err,
    output logic [15:0]                 temperature,
    output logic                        temp_valid
);
    localparam int CW = $clog2(POLL_INTERVAL);
    localparam int TA = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TM = (TIMEOUT > TA) ? TIMEOUT : TA;
    localparam int TW = $clog2(TM + 1);

    localparam logic [CW-1:0] RELOAD     = CW'(POLL_INTERVAL - 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, TX0, TX1, RX0, RX1, HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr;
    logic [7:0]    hi;
    logic [15:0]   sample;
    logic          own;
    logic          push;
    logic          pop;

    // Reset hands the bus back to the host in the same cycle.
    assign own  = busy & ~reset;
    assign push = ((state == TX0) || (state == TX1)) && !spi.wfull;
    assign pop  = ((state == RX0) || (state == RX1)) && !spi.rempty;

    assign spi.wfwe  = own ? push  : host_wfwe;
    assign spi.wfdin = own ? 8'h00 : host_wfdin;
    assign spi.rfre  = own ? pop   : host_rfre;
    assign spi.ncs   = own ? 1'b0  : host_ncs;

`ifdef SPI_TEMP_SEQ_ALIGN_EN
    assign sample = {{3{hi[7]}}, hi, spi.rfdout[7:3]};
`else
    assign sample = {hi, spi.rfdout};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            cnt         <= RELOAD;
            tmr         <= '0;
            hi          <= '0;
            temperature <= '0;
            temp_valid  <= 1'b0;
            collision   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            if (busy && (host_wfwe || host_rfre))
                collision <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (cnt != '0) begin
                        if (enable)
                            cnt <= cnt - 1'b1;
                    end else if (enable && host_ncs && spi.rempty) begin
                        busy  <= 1'b1;
                        tmr   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr == SETUP_LAST)
                        state <= TX0;
                    else
                        tmr <= tmr + 1'b1;
                end
                TX0: begin
                    if (!spi.wfull)
                        state <= TX1;
                end
                TX1: begin
                    if (!spi.wfull) begin
                        tmr   <= '0;
                        state <= RX0;
                    end
                end
                RX0, RX1: begin
                    if (!spi.rempty) begin
                        tmr <= '0;
                        if (state == RX0) begin
                            hi    <= spi.rfdout;
                            state <= RX1;
                        end else begin
                            temperature <= sample;
                            temp_valid  <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (tmr == TO_LAST) begin
                        // Abort: release the bus, keep the old sample.
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        cnt         <= RELOAD;
                        state       <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                HOLD: begin
                    if (tmr == HOLD_LAST) begin
                        busy  <= 1'b0;
                        cnt   <= RELOAD;
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (host_clr_err) begin
                collision   <= 1'b0;
                timeout_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_temp_sequencer.sv
// Scoreboard bench for spi_temp_sequencer with a behavioural SPI core model.
// Random sensor bytes and response latency; expected samples queued per frame.
module tb_spi_temp_sequencer;
    localparam int PI = 16;
    localparam int SU = 4;
    localparam int HO = 4;
    localparam int TO = 64;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       drop;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        host_wfwe;
    logic [7:0]  host_wfdin;
    logic        host_rfre;
    logic        host_ncs;
    logic        host_clr_err;
    logic        busy;
    logic        collision;
    logic        timeout_err;
    logic [15:0] temperature;
    logic        temp_valid;

    spi_temp_sequencer_if bus();

    spi_temp_sequencer #(
        .POLL_INTERVAL(PI),
        .CS_SETUP(SU),
        .CS_HOLD(HO),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .host_wfwe(host_wfwe),
        .host_wfdin(host_wfdin),
        .host_rfre(host_rfre),
        .host_ncs(host_ncs),
        .host_clr_err(host_clr_err),
        .spi(bus),
        .busy(busy),
        .collision(collision),
        .timeout_err(timeout_err),
        .temperature(temperature),
        .temp_valid(temp_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    frame_t      frame_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] cur_temp;

    logic [7:0] rfifo[$];
    logic [7:0] pend_b[$];
    int         pend_t[$];
    int         cyc = 0;
    bit         push_idx = 0;
    bit         slow = 0;
    frame_t     cur_f;
    int         push_cnt = 0;
    int         pop_cnt = 0;
    int         bad_data = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] expect_temp(input logic [7:0] h, input logic [7:0] l);
`ifdef SPI_TEMP_SEQ_ALIGN_EN
        logic signed [15:0] raw;
        raw = $signed({h, l});
        return 16'(raw >>> 3);
`else
        return {h, l};
`endif
    endfunction

    // SPI core model: each dummy byte sent returns one sensor byte later.
    always @(posedge clk) begin
        int due;
        cyc++;
        if (reset) begin
            rfifo.delete();
            pend_b.delete();
            pend_t.delete();
            push_idx = 0;
        end else begin
            if (busy && bus.rfre && rfifo.size() > 0) begin
                void'(rfifo.pop_front());
                pop_cnt++;
            end
            if (busy && bus.wfwe && !bus.wfull) begin
                push_cnt++;
                if (bus.wfdin != 8'h00) bad_data++;
                if (!push_idx)
                    cur_f = (frame_q.size() > 0) ? frame_q.pop_front() : '0;
                if (!(push_idx && cur_f.drop)) begin
                    due = cyc + (slow ? 12 : int'($urandom_range(1, 5)));
                    if (pend_t.size() > 0 && due <= pend_t[$]) due = pend_t[$] + 1;
                    pend_b.push_back(push_idx ? cur_f.lo : cur_f.hi);
                    pend_t.push_back(due);
                end
                push_idx = !push_idx;
            end
            while (pend_t.size() > 0 && pend_t[0] <= cyc) begin
                rfifo.push_back(pend_b.pop_front());
                void'(pend_t.pop_front());
            end
        end
        bus.rempty <= (rfifo.size() == 0);
        bus.rfdout <= (rfifo.size() > 0) ? rfifo[0] : 8'h00;
    end

    // Monitor: every published sample must match the oldest expectation.
    always @(negedge clk) begin
        if (temp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample actual=%0h expected=none", temperature);
            end else begin
                cur_temp = exp_q.pop_front();
                chk("sample", {16'h0, temperature}, {16'h0, cur_temp});
            end
        end
    end

    task automatic run_frame(input logic [7:0] hi, input logic [7:0] lo, input bit drop,
                             input int wfull_at, input bit inj, input int en_off_at,
                             output int fp, output int pk, output int ek, output int ncs_bad);
        frame_t f;
        int n;
        int k;
        f.hi = hi;
        f.lo = lo;
        f.drop = drop;
        frame_q.push_back(f);
        if (!drop) exp_q.push_back(expect_temp(hi, lo));
        fp = -1;
        pk = -1;
        ek = -1;
        ncs_bad = 0;
        n = 0;
        while (!busy && n <= 200) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            chk("start_wait", 32'(busy), 32'd1);
            return;
        end
        push_cnt = 0;
        pop_cnt = 0;
        bad_data = 0;
        k = 0;
        forever begin
            if (k == wfull_at) bus.wfull = 1'b1;
            if (k == wfull_at + 5) bus.wfull = 1'b0;
            if (k == en_off_at) enable = 1'b0;
            if (inj && fp >= 0) begin
                if (k == fp + 1) begin host_wfwe = 1'b1; host_wfdin = 8'hAA; end
                if (k == fp + 2) begin host_wfwe = 1'b0; host_clr_err = 1'b1; end
                if (k == fp + 3) begin host_rfre = 1'b1; host_clr_err = 1'b1; end
                if (k == fp + 4) begin host_rfre = 1'b0; host_clr_err = 1'b0; end
            end
            #1;
            if (bus.wfwe && fp < 0) fp = k;
            if (bus.rfre && pk < 0) pk = k;
            if (bus.ncs !== 1'b0) ncs_bad++;
            if (inj && fp >= 0) begin
                if (k == fp + 1) begin
                    chk("col_wfdin", 32'(bus.wfdin), 32'h0);
                    chk("col_wfwe", 32'(bus.wfwe), 32'h1);
                end
                if (k == fp + 2) chk("col_set", 32'(collision), 32'h1);
                if (k == fp + 3) chk("col_clr", 32'(collision), 32'h0);
                if (k == fp + 4) chk("clr_priority", 32'(collision), 32'h0);
            end
            @(negedge clk);
            k++;
            if (!busy) begin
                ek = k;
                break;
            end
            if (k > 400) begin
                chk("frame_end_wait", 32'(busy), 32'd0);
                break;
            end
        end
    endtask

    task automatic frame_checks(input string tag, input int pushes, input int pops,
                                input int fp, input int fp_exp, input int ncs_bad);
        chk({tag, "_pushes"}, 32'(push_cnt), 32'(pushes));
        chk({tag, "_pops"}, 32'(pop_cnt), 32'(pops));
        chk({tag, "_push_data"}, 32'(bad_data), 32'd0);
        chk({tag, "_first_push"}, 32'(fp), 32'(fp_exp));
        chk({tag, "_ncs_low"}, 32'(ncs_bad), 32'd0);
    endtask

    initial begin
        int fp, pk, ek, nb, nf, k, seen;
        reset = 1'b1;
        enable = 1'b1;
        host_wfwe = 1'b0;
        host_wfdin = 8'h00;
        host_rfre = 1'b0;
        host_ncs = 1'b1;
        host_clr_err = 1'b0;
        bus.wfull = 1'b0;
        cur_temp = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_temp", 32'(temperature), 32'd0);
        chk("rst_valid", 32'(temp_valid), 32'd0);
        chk("rst_flags", {30'd0, collision, timeout_err}, 32'd0);
        chk("rst_ncs", 32'(bus.ncs), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        host_wfwe = 1'b1;
        host_wfdin = 8'h5A;
        host_rfre = 1'b1;
        host_ncs = 1'b0;
        #1;
        chk("idle_mux", {20'd0, bus.wfwe, bus.wfdin, bus.rfre, bus.ncs, 1'b0},
            {20'd0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0});
        host_wfwe = 1'b0;
        host_rfre = 1'b0;
        host_ncs = 1'b1;

        run_frame(8'h19, 8'h80, 0, -1, 0, -1, fp, pk, ek, nf);
        frame_checks("basic", 2, 2, fp, SU, nf);

        for (int i = 0; i < 5; i++) begin
            run_frame(8'($urandom), 8'($urandom), 0, -1, 0, -1, fp, pk, ek, nf);
            frame_checks("rand", 2, 2, fp, SU, nf);
        end

        host_ncs = 1'b0;
        nb = 0;
        for (int i = 0; i < PI + 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || bus.ncs !== 1'b0) nb++;
        end
        chk("host_hold_off", 32'(nb), 32'd0);
        host_ncs = 1'b1;
        @(negedge clk);
        chk("start_on_release", 32'(busy), 32'd1);
        run_frame(8'($urandom), 8'($urandom), 0, -1, 0, -1, fp, pk, ek, nf);
        frame_checks("release", 2, 2, fp, SU, nf);

        run_frame(8'($urandom), 8'($urandom), 0, -1, 1, -1, fp, pk, ek, nf);
        frame_checks("collide", 2, 2, fp, SU, nf);

        run_frame(8'($urandom), 8'($urandom), 0, SU, 0, -1, fp, pk, ek, nf);
        frame_checks("wfull", 2, 2, fp, SU + 5, nf);

        run_frame(8'($urandom), 8'($urandom), 0, -1, 0, 2, fp, pk, ek, nf);
        frame_checks("en_drop", 2, 2, fp, SU, nf);
        nb = 0;
        for (int i = 0; i < 3 * PI; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) nb++;
        end
        chk("no_start_disabled", 32'(nb), 32'd0);
        enable = 1'b1;

        run_frame(8'($urandom), 8'($urandom), 1, -1, 0, -1, fp, pk, ek, nf);
        chk("to_pops", 32'(pop_cnt), 32'd1);
        chk("to_latency", 32'(ek - pk), 32'(TO + 1));
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_release", {30'd0, busy, bus.ncs}, 32'd1);
        chk("to_temp_kept", 32'(temperature), 32'(cur_temp));
        host_clr_err = 1'b1;
        @(negedge clk);
        host_clr_err = 1'b0;
        chk("to_err_clr", 32'(timeout_err), 32'd0);

        frame_q.push_back({8'($urandom), 8'($urandom), 1'b0});
        slow = 1;
        nb = 0;
        while (!busy && nb <= 200) begin
            @(negedge clk);
            nb++;
        end
        chk("rst_frame_start", 32'(busy), 32'd1);
        seen = 0;
        for (k = 0; k < 40 && seen < 2; k++) begin
            host_wfwe = (k == 1);
            #1;
            if (busy && bus.wfwe) seen++;
            @(negedge clk);
        end
        host_wfwe = 1'b0;
        chk("rst_pre_col", 32'(collision), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        slow = 0;
        cur_temp = 16'h0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ncs", 32'(bus.ncs), 32'd1);
        chk("rst_mid_flags", {30'd0, collision, timeout_err}, 32'd0);
        chk("rst_mid_temp", 32'(temperature), 32'd0);

        run_frame(8'($urandom), 8'($urandom), 0, -1, 0, -1, fp, pk, ek, nf);
        frame_checks("post_rst", 2, 2, fp, SU, nf);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
